// File: rtl/bank_req_arb.sv
// Three-channel round-robin arbiter feeding a single bank port, with a post-accept
// cooldown and a credit limit on requests still awaiting a response.
module bank_req_arb #(
    parameter int DATA_W   = 32,
    parameter int BANK_LAT = 2,
    parameter int MAX_OUT  = 4
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [2:0]          ch_req_valid_i,
    input  logic [3*DATA_W-1:0] ch_req_data_i,
    output logic [2:0]          ch_req_ready_o,
    output logic                bank_req_valid_o,
    output logic [DATA_W-1:0]   bank_req_data_o,
    output logic [1:0]          bank_req_ch_o,
    input  logic                bank_req_ready_i,
    input  logic                bank_resp_valid_i,
    output logic [2:0]          outstanding_o,
    output logic                resp_err_o,
    output logic [1:0]          state_o
);

    // Handshakes: a channel transfer happens in the cycle ch_req_valid_i[k] and
    // ch_req_ready_o[k] are both high; a bank transfer happens in the cycle
    // bank_req_valid_o and bank_req_ready_i are both high. Valid never waits on ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        COOL = 2'd2
    } state_t;

    localparam logic [2:0] LAT3 = 3'(BANK_LAT);
    localparam logic [2:0] MAX3 = 3'(MAX_OUT);

    state_t     state_q, state_d;
    logic [1:0] ptr_q;
    logic [2:0] cool_q;
    logic [1:0] sel;
    logic [1:0] cand1, cand2;
    logic       grant;
    logic       accept;

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    // Round-robin pick: ptr first, then ptr+1, then ptr+2 (mod 3).
    always_comb begin
        cand1 = next_ch(ptr_q);
        cand2 = next_ch(cand1);
        if (ch_req_valid_i[ptr_q])      sel = ptr_q;
        else if (ch_req_valid_i[cand1]) sel = cand1;
        else                            sel = cand2;
    end

    assign grant  = (state_q == IDLE) && (|ch_req_valid_i) && (outstanding_o < MAX3);
    assign accept = (state_q == SEND) && bank_req_ready_i;

    always_comb begin
        state_d          = state_q;
        ch_req_ready_o   = 3'b000;
        bank_req_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    ch_req_ready_o = 3'b001 << sel;
                    state_d        = SEND;
                end
            end
            SEND: begin
                bank_req_valid_o = 1'b1;
                if (bank_req_ready_i) state_d = (BANK_LAT > 0) ? COOL : IDLE;
            end
            COOL: begin
                if (cool_q <= 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr_q           <= 2'd0;
            cool_q          <= 3'd0;
            bank_req_data_o <= '0;
            bank_req_ch_o   <= 2'd0;
            outstanding_o   <= 3'd0;
            resp_err_o      <= 1'b0;
        end else begin
            if (grant) begin
                bank_req_data_o <= ch_req_data_i[sel*DATA_W +: DATA_W];
                bank_req_ch_o   <= sel;
            end
            if (accept) ptr_q <= next_ch(bank_req_ch_o);

            if (accept)                                  cool_q <= LAT3;
            else if (state_q == COOL && cool_q != 3'd0)  cool_q <= cool_q - 3'd1;

            // A response landing with an accept cancels out; one with nothing outstanding is an error.
            case ({accept, bank_resp_valid_i})
                2'b10: outstanding_o <= outstanding_o + 3'd1;
                2'b01: begin
                    if (outstanding_o == 3'd0) resp_err_o <= 1'b1;
                    else                       outstanding_o <= outstanding_o - 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_req_arb.sv
// Bench for bank_req_arb: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of grants, cooldown and credits.
module tb_bank_req_arb;

    localparam int DATA_W   = 16;
    localparam int BANK_LAT = 2;
    localparam int MAX_OUT  = 4;

    logic                clk;
    logic                rstn;
    logic [2:0]          ch_req_valid;
    logic [3*DATA_W-1:0] ch_req_data;
    logic [2:0]          ch_req_ready;
    logic                bank_req_valid;
    logic [DATA_W-1:0]   bank_req_data;
    logic [1:0]          bank_req_ch;
    logic                bank_req_ready;
    logic                bank_resp_valid;
    logic [2:0]          outstanding;
    logic                resp_err;
    logic [1:0]          state_dbg;

    int errors = 0;
    int checks = 0;

    // Model: a captured request waiting for the bank, cooldown cycles left, rotating pointer, credits.
    bit                m_pending;
    int                m_ch;
    logic [DATA_W-1:0] m_data;
    int                m_cool;
    int                m_ptr;
    int                m_out;
    bit                m_err;

    bank_req_arb #(.DATA_W(DATA_W), .BANK_LAT(BANK_LAT), .MAX_OUT(MAX_OUT)) dut (
        .clk_i             (clk),
        .rstn_i            (rstn),
        .ch_req_valid_i    (ch_req_valid),
        .ch_req_data_i     (ch_req_data),
        .ch_req_ready_o    (ch_req_ready),
        .bank_req_valid_o  (bank_req_valid),
        .bank_req_data_o   (bank_req_data),
        .bank_req_ch_o     (bank_req_ch),
        .bank_req_ready_i  (bank_req_ready),
        .bank_resp_valid_i (bank_resp_valid),
        .outstanding_o     (outstanding),
        .resp_err_o        (resp_err),
        .state_o           (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_ch      = 0;
        m_data    = '0;
        m_cool    = 0;
        m_ptr     = 0;
        m_out     = 0;
        m_err     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        ch_req_valid    = 3'b000;
        bank_req_ready  = 1'b0;
        bank_resp_valid = 1'b0;
        rstn            = 1'b0;
        #1;
        chk("rst_ch_req_ready", 32'(ch_req_ready), 32'd0);
        chk("rst_bank_valid", 32'(bank_req_valid), 32'd0);
        chk("rst_bank_data", 32'(bank_req_data), 32'd0);
        chk("rst_bank_ch", 32'(bank_req_ch), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic [2:0] v, input logic br, input logic rsp);
        int         win;
        bit         acc;
        logic [2:0] exp_rdy;
        @(negedge clk);
        ch_req_valid    = v;
        ch_req_data     = {16'($urandom), 16'($urandom), 16'($urandom)};
        bank_req_ready  = br;
        bank_resp_valid = rsp;
        #1;
        win = -1;
        if (!m_pending && m_cool == 0 && m_out < MAX_OUT && v != 3'b000)
            for (int k = 0; k < 3; k++)
                if (win < 0 && v[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
        exp_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;

        chk("ch_req_ready", 32'(ch_req_ready), 32'(exp_rdy));
        chk("bank_req_valid", 32'(bank_req_valid), 32'(m_pending));
        chk("outstanding", 32'(outstanding), 32'(m_out));
        chk("resp_err", 32'(resp_err), 32'(m_err));
        if (m_pending) begin
            chk("bank_req_data", 32'(bank_req_data), 32'(m_data));
            chk("bank_req_ch", 32'(bank_req_ch), 32'(m_ch));
        end

        acc = m_pending && br;
        if (acc) begin
            m_ptr     = (m_ch + 1) % 3;
            m_pending = 1'b0;
            m_cool    = BANK_LAT;
        end else if (m_cool > 0) begin
            m_cool--;
        end
        if (win >= 0) begin
            m_pending = 1'b1;
            m_ch      = win;
            m_data    = ch_req_data[win*DATA_W +: DATA_W];
        end
        if (acc && !rsp) m_out++;
        else if (!acc && rsp) begin
            if (m_out == 0) m_err = 1'b1;
            else            m_out--;
        end
    endtask

    task automatic run(input logic [2:0] v, input logic br, input logic rsp, input int n);
        for (int i = 0; i < n; i++) step(v, br, rsp);
    endtask

    initial begin
        rstn            = 1'b0;
        ch_req_valid    = 3'b000;
        ch_req_data     = '0;
        bank_req_ready  = 1'b0;
        bank_resp_valid = 1'b0;
        model_reset();

        do_reset();

        // Fairness: all channels requesting, bank always ready -> ch0, ch1, ch2, ch0 every 4 cycles.
        run(3'b111, 1'b1, 1'b0, 16);
        // Credit limit reached: no grant until a response frees a credit.
        run(3'b111, 1'b1, 1'b0, 4);
        run(3'b111, 1'b1, 1'b1, 1);
        run(3'b111, 1'b1, 1'b0, 4);
        run(3'b000, 1'b1, 1'b1, 4);

        // Bank backpressure for 5 SEND cycles, then accept coinciding with a response.
        run(3'b111, 1'b0, 1'b0, 6);
        run(3'b111, 1'b1, 1'b1, 1);
        run(3'b000, 1'b1, 1'b0, 3);

        // Wrap and skip: ch1 first leaves ptr at 2, then 011 -> ch0, then 101 -> ch2.
        do_reset();
        run(3'b010, 1'b1, 1'b0, 4);
        run(3'b011, 1'b1, 1'b0, 4);
        run(3'b101, 1'b1, 1'b0, 4);

        // Drain credits, then extra responses at zero raise the sticky error.
        run(3'b000, 1'b1, 1'b1, 5);
        run(3'b000, 1'b1, 1'b0, 2);

        // Reset while a request is pending at the bank; arbitration restarts from ch0.
        run(3'b111, 1'b0, 1'b0, 2);
        do_reset();
        run(3'b110, 1'b1, 1'b0, 4);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3));

        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bank_req_arb.md
BANK_REQ_ARB -- requirements
Module: bank_req_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, request payload width per channel.
REQ-002 SHALL have parameter BANK_LAT, default 2, number of bank cooldown cycles after each bank acceptance (legal range 0..7).
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum number of bank requests outstanding without a response (legal range 1..7).
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 ch_req_valid_i  input  3  per-channel request valid.
REQ-007 ch_req_data_i  input  3*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 ch_req_ready_o  output  3  per-channel accept; at most one bit is set per cycle.
REQ-009 bank_req_valid_o  output  1  bank request valid.
REQ-010 bank_req_data_o  output  DATA_W  registered payload of the granted channel.
REQ-011 bank_req_ch_o  output  2  granted channel id (0..2).
REQ-012 bank_req_ready_i  input  1  bank accepts the request.
REQ-013 bank_resp_valid_i  input  1  one pulse per completed bank request; returns one credit.
REQ-014 outstanding_o  output  3  current outstanding count.
REQ-015 resp_err_o  output  1  sticky flag: a response arrived while the outstanding count was 0.

Function
REQ-016 SHALL implement the FSM states IDLE, SEND and COOL.
REQ-017 IDLE, grant condition: at least one ch_req_valid_i bit is set, and outstanding_o < MAX_OUT.
REQ-018 IDLE, channel selection: round-robin starting at ptr, checking ptr, ptr+1, ptr+2 in that order (mod 3); the first valid channel wins.
REQ-019 IDLE, on grant: ch_req_ready_o[sel]=1 combinationally in the same cycle; the payload is captured into bank_req_data_o and sel into bank_req_ch_o; next state is SEND.
REQ-020 ch_req_ready_o SHALL be all zero in SEND and COOL, and in IDLE when the grant condition is false.
REQ-021 SEND: bank_req_valid_o=1, with data and ch held stable until bank_req_ready_i=1.
REQ-022 SEND, on bank_req_ready_i=1:
- ptr <= sel+1, wrapping 2 to 0.
- outstanding increments by 1.
- Next state is COOL if BANK_LAT>0, otherwise IDLE.
REQ-023 COOL: load the counter with BANK_LAT on entry, decrement it each cycle, and go to IDLE in the cycle the counter reaches 1; this gives exactly BANK_LAT cycles in COOL.
REQ-024 ptr SHALL change only on bank acceptance; a channel that drops its valid after being granted does not affect the captured request.
REQ-025 Outstanding counter, simultaneous bank accept and bank_resp_valid_i in one cycle: the count is unchanged.
REQ-026 Outstanding counter, response with count 0 and no simultaneous accept: the count stays 0 and resp_err_o is set until reset.
REQ-027 Outstanding counter SHALL never exceed MAX_OUT; when the count equals MAX_OUT, IDLE grants nothing.
REQ-028 Grant-to-bank latency: a request accepted in cycle N SHALL present bank_req_valid_o=1 in cycle N+1.
REQ-029 Maximum throughput is one grant per 2+BANK_LAT cycles when the bank is always ready.
REQ-030 bank_req_valid_o SHALL be 0 in IDLE and COOL.

Reset
REQ-031 On rstn_i low, asynchronously: state=IDLE, ptr=0, cooldown counter=0, outstanding_o=0, resp_err_o=0, bank_req_valid_o=0, bank_req_data_o=0, bank_req_ch_o=0, ch_req_ready_o=0.
REQ-032 Reset asserted in SEND or COOL SHALL drop the pending request without issuing it; after release, arbitration restarts from channel 0.

Verification
REQ-033 Three-channel fairness: valid=3'b111, bank always ready, BANK_LAT=2 -> grants in order ch0, ch1, ch2, ch0, with one grant every 4 cycles.
REQ-034 Wrap and skip: ptr=2, valid=3'b011 -> ch0 granted, ptr becomes 1; next with valid=3'b101 -> ch2 granted, ptr becomes 0.
REQ-035 Bank backpressure: bank_req_ready_i=0 for 5 cycles in SEND -> bank_req_valid_o, data and ch stable for all 5 cycles, no ch_req_ready_o pulse, ptr unchanged.
REQ-036 Credit limit: MAX_OUT=4, no responses, 4 grants -> outstanding_o=4 and no fifth grant; one bank_resp_valid_i pulse -> a fifth grant occurs the next IDLE cycle.
REQ-037 Simultaneous and erroneous responses:
- Response coinciding with a bank accept -> outstanding_o unchanged.
- Response at outstanding 0 -> resp_err_o=1 and outstanding_o=0.
REQ-038 Reset mid-SEND: rstn_i pulsed low while bank_req_valid_o=1 -> all outputs 0; after release, valid=3'b110 -> ch1 granted first.
